// File: rtl/dac_pkg.sv
// Shared constants, FSM state type and sample-to-frame formatting for the DAC streamer.
// Optional build macro: DAC_TWOS_COMPLEMENT_EN (two's complement input samples).
package dac_pkg;

    localparam int DAC_SAMPLE_W = 12;
    localparam int DAC_FRAME_W  = 16;
    localparam int FRAME_BYTES  = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        READY   = 2'd1,
        SEND    = 2'd2
    } state_t;

    // Builds the 16-bit DAC word: four leading zero bits, then the sample in offset binary.
    function automatic logic [DAC_FRAME_W-1:0] frame_word(input logic [DAC_SAMPLE_W-1:0] sample);
`ifdef DAC_TWOS_COMPLEMENT_EN
        return {{(DAC_FRAME_W-DAC_SAMPLE_W){1'b0}}, ~sample[DAC_SAMPLE_W-1], sample[DAC_SAMPLE_W-2:0]};
`else
        return {{(DAC_FRAME_W-DAC_SAMPLE_W){1'b0}}, sample};
`endif
    endfunction

endpackage

// File: rtl/dac_spi_dual.sv
// Dual-channel serializer: shifts two 16-bit words MSB first in lockstep, framed by sync_n.
// Data changes on sclk rising edges so it is stable across each falling edge.
module dac_spi_dual
    import dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DAC_FRAME_W-1:0] left,
    input  logic [DAC_FRAME_W-1:0] right,
    output logic                   busy,
    output logic                   done,
    output logic                   sync_n,
    output logic                   sclk,
    output logic                   din_l,
    output logic                   din_r
);

    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int HALF_W = $clog2(2*DAC_FRAME_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2*DAC_FRAME_W);

    logic                   active_reg;
    logic                   done_reg;
    logic                   sync_n_reg;
    logic                   sclk_reg;
    logic [DAC_FRAME_W-1:0] sh_l_reg;
    logic [DAC_FRAME_W-1:0] sh_r_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [HALF_W-1:0]      half_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
            sync_n_reg <= 1'b1;
            sclk_reg   <= 1'b1;
            sh_l_reg   <= '0;
            sh_r_reg   <= '0;
            div_reg    <= '0;
            half_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (done_reg) begin
                active_reg <= 1'b0;
            end else if (!active_reg) begin
                if (start) begin
                    active_reg <= 1'b1;
                    sync_n_reg <= 1'b0;
                    sclk_reg   <= 1'b1;
                    sh_l_reg   <= left;
                    sh_r_reg   <= right;
                    div_reg    <= '0;
                    half_reg   <= '0;
                end
            end else if (!sync_n_reg) begin
                // One extra sclk-high period after the last falling edge, then release sync.
                if (half_reg == LAST_HALF) begin
                    sync_n_reg <= 1'b1;
                    done_reg   <= 1'b1;
                end else if (div_reg == DIV_LAST) begin
                    div_reg  <= '0;
                    half_reg <= half_reg + 1'b1;
                    if (!half_reg[0]) begin
                        sclk_reg <= 1'b0;
                    end else begin
                        sclk_reg <= 1'b1;
                        sh_l_reg <= {sh_l_reg[DAC_FRAME_W-2:0], 1'b0};
                        sh_r_reg <= {sh_r_reg[DAC_FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    div_reg <= div_reg + 1'b1;
                end
            end
        end
    end

    // start is itself a registered pulse, so busy covers the start cycle without delay.
    assign busy   = active_reg | start;
    assign done   = done_reg;
    assign sync_n = sync_n_reg;
    assign sclk   = sclk_reg;
    assign din_l  = sh_l_reg[DAC_FRAME_W-1];
    assign din_r  = sh_r_reg[DAC_FRAME_W-1];

endmodule

// File: rtl/dac_sample_streamer.sv
// Collects 4-byte USB frames into L/R samples and releases one per sample tick to a dual SPI DAC.
// Optional build macro: DAC_TWOS_COMPLEMENT_EN (flip sample MSB to convert to offset binary).
module dac_sample_streamer
    import dac_pkg::*;
#(
    parameter int SAMPLE_DIV = 2268,
    parameter int SCLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din_l,
    output logic        dac_din_r,
    output logic [15:0] underrun_count,
    output logic        busy
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);

    generate
        if (SAMPLE_DIV < 32*SCLK_DIV + 8) begin : g_bad_div
            $error("SAMPLE_DIV too small for one serializer frame plus turnaround");
        end
    endgenerate

    state_t                              state_reg;
    logic [1:0]                          byte_idx_reg;
    logic                                start_reg;
    logic [CNT_W-1:0]                    tick_cnt_reg;
    logic [15:0]                         underrun_reg;
    logic [1:0][DAC_SAMPLE_W-1:0]        samples;
    logic                                tick;
    logic                                accept;
    logic                                spi_done;

    assign in_ready = (state_reg == COLLECT);
    assign accept   = in_ready && in_valid;
    assign tick     = en && (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else if (!en || tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // Even bytes carry sample[7:0]; only the low nibble of odd bytes is kept.
    generate
        for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_byte
            if (gi % 2 == 0) begin : g_lo
                logic [7:0] byte_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        byte_reg <= '0;
                    end else if (accept && byte_idx_reg == 2'(gi)) begin
                        byte_reg <= in_data;
                    end
                end
                assign samples[gi/2][7:0] = byte_reg;
            end else begin : g_hi
                logic [3:0] byte_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        byte_reg <= '0;
                    end else if (accept && byte_idx_reg == 2'(gi)) begin
                        byte_reg <= in_data[3:0];
                    end
                end
                assign samples[gi/2][11:8] = byte_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= COLLECT;
            byte_idx_reg <= '0;
            start_reg    <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    if (accept) begin
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg <= READY;
                        end
                    end
                end
                READY: begin
                    if (tick) begin
                        start_reg <= 1'b1;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (spi_done) begin
                        state_reg    <= COLLECT;
                        byte_idx_reg <= '0;
                    end
                end
                default: begin
                    state_reg    <= COLLECT;
                    byte_idx_reg <= '0;
                end
            endcase
        end
    end

    // Any tick that cannot launch a frame is a missed sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_reg <= '0;
        end else if (tick && state_reg != READY && underrun_reg != 16'hFFFF) begin
            underrun_reg <= underrun_reg + 1'b1;
        end
    end

    assign underrun_count = underrun_reg;

    dac_spi_dual #(
        .SCLK_DIV(SCLK_DIV)
    ) u_spi (
        .clk    (clk),
        .reset  (reset),
        .start  (start_reg),
        .left   (frame_word(samples[0])),
        .right  (frame_word(samples[1])),
        .busy   (busy),
        .done   (spi_done),
        .sync_n (dac_sync_n),
        .sclk   (dac_sclk),
        .din_l  (dac_din_l),
        .din_r  (dac_din_r)
    );

endmodule
